scc_mem_dump_ctrl: RTL and testbench
====================================

Name: scc_mem_dump_ctrl

Overview:
- Post-HALT memory dump sequencer for the SCC top.
- When the core raises halt_f, the block takes ownership of the byte-wide data-memory read port.
- It walks the address window [START_ADDR, END_ADDR] in 4-byte steps and assembles big-endian 32-bit words, MSB at the lowest address.
- It emits (address, word) records over a valid/ready stream to the dump writer, which produces the address,value lines that are compared against the emulator's dataoutput.csv.

Parameters:
- ADDR_W, 16, byte-address width of data memory.
- START_ADDR, 0, first word address dumped; must be a multiple of 4.
- END_ADDR, 16'hFFFC, last word address dumped; must be a multiple of 4 and >= START_ADDR.
- SKIP_ZERO, 1, 1 = words equal to 0 produce no record; 0 = every word is emitted.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- halt_f  input  1  core HALT flag; sticky in the core.
- mem_grant  output  1  1 = dump owns the memory read port; top-level mux selects mem_addr/mem_rd_en over the core's.
- mem_addr  output  ADDR_W  byte read address.
- mem_rd_en  output  1  read strobe; mem_rdata is valid exactly 1 cycle later.
- mem_rdata  input  8  read data byte.
- rec_valid  output  1  record available.
- rec_ready  input  1  sink accepts the record.
- rec_addr  output  ADDR_W  word address of the record.
- rec_data  output  32  {m[a], m[a+1], m[a+2], m[a+3]}.
- rec_count  output  ADDR_W-1  number of records accepted so far.
- busy  output  1  dump in progress.
- done  output  1  dump complete; sticky until reset.

Behaviour:
- Reset values (rst low, asynchronous): all outputs 0; state IDLE; address pointer = START_ADDR.
- States and transitions:
  - IDLE: if halt_f=1 and done=0 -> GRANT. halt_f already high when reset releases also starts a dump.
  - GRANT: one cycle; mem_grant rises, mem_rd_en=0. This gives one turnaround cycle for the memory mux. -> FETCH.
  - FETCH: four consecutive cycles with mem_rd_en=1 and mem_addr = ptr+0, +1, +2, +3.
  - Capture: byte k is captured on the cycle after its issue into byte lane k (k=0 -> bits 31:24).
  - -> LAST.
  - LAST: capture byte 3; word complete. If SKIP_ZERO and word==0 -> NEXT, otherwise -> EMIT.
  - EMIT: rec_valid=1. rec_addr and rec_data are held stable while rec_valid=1 and rec_ready=0. A transfer happens on the cycle with rec_valid & rec_ready; on that cycle rec_count increments and the state goes -> NEXT.
  - rec_ready is allowed to be high before rec_valid; no combinational path from rec_ready to rec_valid.
  - NEXT: if ptr==END_ADDR -> DONE; otherwise ptr += 4 -> FETCH.
  - The END_ADDR comparison is made before the increment, so END_ADDR=16'hFFFC never wraps to 0.
  - DONE: mem_grant=0, busy=0, done=1; stays here until reset.
- busy = 1 in every state except IDLE and DONE. mem_grant = 1 in GRANT through NEXT.
- Latency, nonzero word, immediate ready: 1 (GRANT) + 4 (FETCH) + 1 (LAST) + 1 (EMIT) + 1 (NEXT) = 8 cycles for the first word, 7 cycles per word after that.
- halt_f deasserting mid-dump is ignored; the dump runs to completion.
- Reset mid-dump aborts immediately: mem_grant drops asynchronously, any pending record is discarded, and a new dump starts when halt_f is seen again.
- rec_count saturates at its maximum value. It cannot overflow with legal parameters: the maximum is (END_ADDR-START_ADDR)/4+1 = 16384 records, which fits in 15 bits.
- Exactly one mem_rd_en per byte; no reads outside [START_ADDR, END_ADDR+3].

Decomposition:
- Shared package scc_dump_pkg holds:
  - state enum constants S_IDLE, S_GRANT, S_FETCH, S_LAST, S_EMIT, S_NEXT, S_DONE (3-bit);
  - BYTES_PER_WORD=4;
  - default window constants.
- One natural sub-module, scc_word_assembler: the 2-bit byte-lane counter plus a 32-bit shift/lane register. Interface: clear, capture strobe, byte in, 32-bit word out, word_complete.
- The FSM, pointer and stream logic stay in the top module.

Test Plan:
- Memory all zero, SKIP_ZERO=1, halt_f pulse: zero records; done=1 after 16384*6+1 cycles; exactly 65536 mem_rd_en pulses.
- m[0x10..0x13]=DE AD BE EF, rest 0: single record rec_addr=0x0010, rec_data=0xDEADBEEF, rec_count=1.
- SKIP_ZERO=0, START=0x0, END=0x8, m[4..7]=01 02 03 04: three records {0x0,0}, {0x4,0x01020304}, {0x8,0}; mem_grant high throughout, then done.
- Backpressure: rec_ready held low 10 cycles during EMIT: rec_valid, rec_addr and rec_data stable all 10 cycles; the record is transferred exactly once and rec_count increments by 1.
- Wrap boundary: m[0xFFFC..0xFFFF]=11 22 33 44, END=0xFFFC: last record {0xFFFC, 0x11223344}; no read at address 0x0000 afterwards; done=1.
- Reset asserted during the 3rd FETCH cycle: all outputs 0 immediately. After release with halt_f still high, the dump restarts from START_ADDR and emits the full record set again.

Source files
------------

// File: rtl/scc_dump_pkg.sv
// scc_dump_pkg: shared definitions for the post-HALT memory dump sequencer.
//   state_e          dump FSM encoding (3-bit)
//   BYTES_PER_WORD   bytes assembled per dumped record
//   DEF_*_ADDR       default dump window (whole 64 KiB data memory)
package scc_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_FETCH = 3'd2,
    S_LAST  = 3'd3,
    S_EMIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [15:0] DEF_START_ADDR = 16'h0000;
  localparam logic [15:0] DEF_END_ADDR   = 16'hFFFC;

endpackage

// File: rtl/scc_word_assembler.sv
// scc_word_assembler: packs four sequential read bytes into a big-endian word.
//   clk, rst          clock, async active-low reset
//   i_clear           restart at lane 0 with an all-zero word
//   i_capture         i_byte is valid this cycle; store it in the current lane
//   i_byte            read data byte
//   o_word            assembled word, lane 0 in bits 31:24 (registered)
//   o_word_complete   the byte captured this cycle is lane 3
module scc_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_capture,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_complete
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_lane <= 2'd0;
      r_word <= 32'd0;
    end else if (i_capture) begin
      case (r_lane)
        2'd0:    r_word[31:24] <= i_byte;
        2'd1:    r_word[23:16] <= i_byte;
        2'd2:    r_word[15:8]  <= i_byte;
        default: r_word[7:0]   <= i_byte;
      endcase
      r_lane <= r_lane + 2'd1;
    end
  end

  assign o_word          = r_word;
  assign o_word_complete = i_capture && (r_lane == 2'd3);

endmodule

// File: rtl/scc_mem_dump_ctrl.sv
// scc_mem_dump_ctrl: after core HALT, takes the byte-wide data-memory read
// port, walks [START_ADDR, END_ADDR] in word steps and streams big-endian
// (address, word) records to the dump writer.
//   clk, rst                 clock, async active-low reset
//   halt_f                   core HALT flag (starts the dump)
//   mem_grant                dump owns the memory read port
//   mem_addr/mem_rd_en       byte read request; mem_rdata valid 1 cycle later
//   mem_rdata                read data byte
//   rec_valid/rec_ready      record stream handshake
//   rec_addr/rec_data        record word address and big-endian word
//   rec_count                records accepted (saturating)
//   busy/done                dump in progress / finished (sticky)
module scc_mem_dump_ctrl import scc_dump_pkg::*; #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR),
  parameter bit                SKIP_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_f,
  output logic              mem_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [31:0]       rec_data,
  output logic [ADDR_W-2:0] rec_count,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(BYTES_PER_WORD);
  localparam logic [ADDR_W-2:0] CNT_ONE   = (ADDR_W-1)'(1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [1:0]        r_fcnt;
  logic              r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_en;
  logic              r_rd_d;     // read issued last cycle -> mem_rdata valid now
  logic              r_valid;
  logic [ADDR_W-1:0] r_rec_addr;
  logic [31:0]       r_rec_data;
  logic [ADDR_W-2:0] r_count;
  logic              r_busy;
  logic              r_done;

  logic        w_clear;
  logic [31:0] w_word;
  logic        w_word_complete;
  logic [31:0] w_full;

  // Lane counter restarts before every word's first fetch.
  assign w_clear = (r_state == S_GRANT) || (r_state == S_NEXT);

  scc_word_assembler u_asm (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_clear),
    .i_capture       (r_rd_d),
    .i_byte          (mem_rdata),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  // In LAST lane 3 is still zero in the register; merge the byte arriving now
  // so the skip/emit decision does not cost an extra cycle.
  assign w_full = w_word | {24'd0, mem_rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= START_ADDR;
      r_fcnt     <= 2'd0;
      r_grant    <= 1'b0;
      r_addr     <= '0;
      r_rd_en    <= 1'b0;
      r_rd_d     <= 1'b0;
      r_valid    <= 1'b0;
      r_rec_addr <= '0;
      r_rec_data <= 32'd0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_d <= r_rd_en;
      case (r_state)
        S_IDLE: begin
          if (halt_f && !r_done) begin
            r_state <= S_GRANT;
            r_grant <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          // Turnaround cycle for the memory mux; first read goes out next.
          r_state <= S_FETCH;
          r_addr  <= r_ptr;
          r_rd_en <= 1'b1;
          r_fcnt  <= 2'd0;
        end
        S_FETCH: begin
          if (r_fcnt == 2'd3) begin
            r_rd_en <= 1'b0;
            r_state <= S_LAST;
          end else begin
            r_addr <= r_addr + ADDR_ONE;
            r_fcnt <= r_fcnt + 2'd1;
          end
        end
        S_LAST: begin
          if (w_word_complete) begin
            if (SKIP_ZERO && (w_full == 32'd0)) begin
              r_state <= S_NEXT;
            end else begin
              r_rec_addr <= r_ptr;
              r_rec_data <= w_full;
              r_valid    <= 1'b1;
              r_state    <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (rec_ready) begin
            r_valid <= 1'b0;
            if (r_count != '1) r_count <= r_count + CNT_ONE;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          // Compare before incrementing so a window ending at the top of
          // memory never wraps back to address 0.
          if (r_ptr == END_ADDR) begin
            r_state <= S_DONE;
            r_grant <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_ptr   <= r_ptr + WORD_STEP;
            r_addr  <= r_ptr + WORD_STEP;
            r_rd_en <= 1'b1;
            r_fcnt  <= 2'd0;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_grant = r_grant;
  assign mem_addr  = r_addr;
  assign mem_rd_en = r_rd_en;
  assign rec_valid = r_valid;
  assign rec_addr  = r_rec_addr;
  assign rec_data  = r_rec_data;
  assign rec_count = r_count;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_scc_mem_dump_ctrl.sv
// Directed bench: instance A dumps window 0xFFC0..0xFFFC with zero skipping,
// instance B dumps 0x0..0x8 emitting every word.
module tb_scc_mem_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic        rst_a, halt_a, grant_a, rd_a, valid_a, ready_a, busy_a, done_a;
  logic [15:0] addr_a, raddr_a;
  logic [7:0]  rdata_a = 8'd0;
  logic [31:0] rdat_a;
  logic [14:0] cnt_a;

  scc_mem_dump_ctrl #(.ADDR_W(16), .START_ADDR(16'hFFC0), .END_ADDR(16'hFFFC),
                      .SKIP_ZERO(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .halt_f(halt_a), .mem_grant(grant_a),
    .mem_addr(addr_a), .mem_rd_en(rd_a), .mem_rdata(rdata_a),
    .rec_valid(valid_a), .rec_ready(ready_a), .rec_addr(raddr_a),
    .rec_data(rdat_a), .rec_count(cnt_a), .busy(busy_a), .done(done_a));

  // ---------------- instance B ----------------
  logic        rst_b, halt_b, grant_b, rd_b, valid_b, ready_b, busy_b, done_b;
  logic [15:0] addr_b, raddr_b;
  logic [7:0]  rdata_b = 8'd0;
  logic [31:0] rdat_b;
  logic [14:0] cnt_b;

  scc_mem_dump_ctrl #(.ADDR_W(16), .START_ADDR(16'h0000), .END_ADDR(16'h0008),
                      .SKIP_ZERO(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .halt_f(halt_b), .mem_grant(grant_b),
    .mem_addr(addr_b), .mem_rd_en(rd_b), .mem_rdata(rdata_b),
    .rec_valid(valid_b), .rec_ready(ready_b), .rec_addr(raddr_b),
    .rec_data(rdat_b), .rec_count(cnt_b), .busy(busy_b), .done(done_b));

  // memory models: data valid one cycle after the read strobe
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  always @(posedge clk) if (rd_a) rdata_a <= mem_a[addr_a];
  always @(posedge clk) if (rd_b) rdata_b <= mem_b[addr_b];

  // monitors sample on the falling edge
  int          rd_cnt_a = 0, oob_a = 0, rd_cnt_b = 0, oob_b = 0;
  logic [15:0] last_rd_a = 16'd0;
  logic [15:0] qa_addr[$], qb_addr[$];
  logic [31:0] qa_data[$], qb_data[$];

  always @(negedge clk) begin
    if (rd_a) begin
      rd_cnt_a++;
      last_rd_a = addr_a;
      if (addr_a < 16'hFFC0) oob_a++;
    end
    if (valid_a && ready_a) begin
      qa_addr.push_back(raddr_a);
      qa_data.push_back(rdat_a);
    end
    if (rd_b) begin
      rd_cnt_b++;
      if (addr_b > 16'h000B) oob_b++;
    end
    if (valid_b && ready_b) begin
      qb_addr.push_back(raddr_b);
      qb_data.push_back(rdat_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, base_rd, base_q, drops;
    rst_a = 1'b0; rst_b = 1'b0; halt_a = 1'b0; halt_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 8'd0;
      mem_b[i] = 8'd0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {31'd0, grant_a}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_addr", {16'd0, addr_a}, 32'd0);
    chk("rst_rec_data", rdat_a, 32'd0);
    chk("rst_count", {17'd0, cnt_a}, 32'd0);

    // ---- phase 1: all-zero window, halt pulse -> no records ----
    base_rd = rd_cnt_a;
    rst_a = 1'b1;
    @(posedge clk); #1 halt_a = 1'b1;
    @(posedge clk); #1 halt_a = 1'b0;
    chk("p1_grant", {31'd0, grant_a}, 32'd1);
    chk("p1_busy", {31'd0, busy_a}, 32'd1);
    chk("p1_rd_in_grant", {31'd0, rd_a}, 32'd0);
    n = 0;
    while (!done_a && n < 2000) begin @(posedge clk); #1; n++; end
    chk("p1_cycles", 32'(n), 32'd97);
    chk("p1_done", {31'd0, done_a}, 32'd1);
    chk("p1_busy_end", {31'd0, busy_a}, 32'd0);
    chk("p1_grant_end", {31'd0, grant_a}, 32'd0);
    chk("p1_reads", 32'(rd_cnt_a - base_rd), 32'd64);
    chk("p1_records", 32'(qa_addr.size()), 32'd0);
    chk("p1_count", {17'd0, cnt_a}, 32'd0);
    // done is sticky: halt again must not start another dump
    base_rd = rd_cnt_a;
    halt_a = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("p1_no_restart_busy", {31'd0, busy_a}, 32'd0);
    chk("p1_no_restart_reads", 32'(rd_cnt_a - base_rd), 32'd0);

    // ---- phase 2: two nonzero words, backpressure on the first ----
    rst_a = 1'b0;
    ready_a = 1'b0;
    mem_a[16'hFFE0] = 8'hDE; mem_a[16'hFFE1] = 8'hAD;
    mem_a[16'hFFE2] = 8'hBE; mem_a[16'hFFE3] = 8'hEF;
    mem_a[16'hFFFC] = 8'h11; mem_a[16'hFFFD] = 8'h22;
    mem_a[16'hFFFE] = 8'h33; mem_a[16'hFFFF] = 8'h44;
    @(posedge clk); #1;
    chk("p2_done_cleared", {31'd0, done_a}, 32'd0);
    base_rd = rd_cnt_a;
    base_q  = qa_addr.size();
    rst_a = 1'b1;  // halt_a is already high at release
    n = 0;
    while (!valid_a && n < 500) begin @(posedge clk); #1; n++; end
    chk("p2_first_valid_cycle", 32'(n), 32'd55);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, valid_a}, 32'd1);
      chk("bp_addr", {16'd0, raddr_a}, 32'h0000FFE0);
      chk("bp_data", rdat_a, 32'hDEADBEEF);
    end
    chk("bp_count_held", {17'd0, cnt_a}, 32'd0);
    ready_a = 1'b1;
    @(posedge clk); #1;
    chk("bp_count_after", {17'd0, cnt_a}, 32'd1);
    chk("bp_valid_after", {31'd0, valid_a}, 32'd0);
    n = 0;
    while (!done_a && n < 500) begin @(posedge clk); #1; n++; end
    chk("p2_done", {31'd0, done_a}, 32'd1);
    chk("p2_records", 32'(qa_addr.size() - base_q), 32'd2);
    chk("p2_rec0_addr", {16'd0, qa_addr[base_q]}, 32'h0000FFE0);
    chk("p2_rec0_data", qa_data[base_q], 32'hDEADBEEF);
    chk("p2_rec1_addr", {16'd0, qa_addr[base_q+1]}, 32'h0000FFFC);
    chk("p2_rec1_data", qa_data[base_q+1], 32'h11223344);
    chk("p2_count", {17'd0, cnt_a}, 32'd2);
    chk("p2_reads", 32'(rd_cnt_a - base_rd), 32'd64);
    chk("p2_last_read", {16'd0, last_rd_a}, 32'h0000FFFF);
    chk("p2_oob_reads", 32'(oob_a), 32'd0);

    // ---- phase 3: reset during the third FETCH cycle ----
    rst_a = 1'b0;
    @(posedge clk); #1 rst_a = 1'b1;
    @(posedge clk); #1;   // GRANT
    @(posedge clk); #1;   // FETCH 1
    @(posedge clk); #1;   // FETCH 2
    @(posedge clk); #1;   // FETCH 3
    chk("p3_fetch3_rd", {31'd0, rd_a}, 32'd1);
    chk("p3_fetch3_addr", {16'd0, addr_a}, 32'h0000FFC2);
    rst_a = 1'b0;
    #1;
    chk("p3_async_grant", {31'd0, grant_a}, 32'd0);
    chk("p3_async_rd", {31'd0, rd_a}, 32'd0);
    chk("p3_async_busy", {31'd0, busy_a}, 32'd0);
    chk("p3_async_addr", {16'd0, addr_a}, 32'd0);
    chk("p3_async_count", {17'd0, cnt_a}, 32'd0);
    base_rd = rd_cnt_a;
    base_q  = qa_addr.size();
    @(posedge clk); #1 rst_a = 1'b1;
    n = 0;
    while (!done_a && n < 500) begin @(posedge clk); #1; n++; end
    chk("p3_done", {31'd0, done_a}, 32'd1);
    chk("p3_records", 32'(qa_addr.size() - base_q), 32'd2);
    chk("p3_rec0_addr", {16'd0, qa_addr[base_q]}, 32'h0000FFE0);
    chk("p3_rec0_data", qa_data[base_q], 32'hDEADBEEF);
    chk("p3_rec1_addr", {16'd0, qa_addr[base_q+1]}, 32'h0000FFFC);
    chk("p3_rec1_data", qa_data[base_q+1], 32'h11223344);
    chk("p3_count", {17'd0, cnt_a}, 32'd2);
    chk("p3_reads", 32'(rd_cnt_a - base_rd), 32'd64);
    chk("p3_oob_reads", 32'(oob_a), 32'd0);

    // ---- phase 4: instance B, SKIP_ZERO=0, window 0x0..0x8 ----
    mem_b[4] = 8'h01; mem_b[5] = 8'h02; mem_b[6] = 8'h03; mem_b[7] = 8'h04;
    rst_b = 1'b1;
    @(posedge clk); #1 halt_b = 1'b1;
    @(posedge clk); #1;
    chk("p4_grant", {31'd0, grant_b}, 32'd1);
    n = 0;
    drops = 0;
    while (!done_b && n < 500) begin
      @(posedge clk); #1; n++;
      if (!done_b && !grant_b) drops++;
    end
    chk("p4_cycles", 32'(n), 32'd22);
    chk("p4_grant_drops", 32'(drops), 32'd0);
    chk("p4_done", {31'd0, done_b}, 32'd1);
    chk("p4_grant_end", {31'd0, grant_b}, 32'd0);
    chk("p4_records", 32'(qb_addr.size()), 32'd3);
    chk("p4_rec0_addr", {16'd0, qb_addr[0]}, 32'h0);
    chk("p4_rec0_data", qb_data[0], 32'h0);
    chk("p4_rec1_addr", {16'd0, qb_addr[1]}, 32'h4);
    chk("p4_rec1_data", qb_data[1], 32'h01020304);
    chk("p4_rec2_addr", {16'd0, qb_addr[2]}, 32'h8);
    chk("p4_rec2_data", qb_data[2], 32'h0);
    chk("p4_count", {17'd0, cnt_b}, 32'd3);
    chk("p4_reads", 32'(rd_cnt_b), 32'd12);
    chk("p4_oob_reads", 32'(oob_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
